// File: rtl/online_adder_seq_r4.sv
// online_adder_seq_r4
// Drives a radix-4 online adder through NUM_TST test vectors per run. Each
// vector is selected on an external combinational ROM, latched, streamed
// MSD-first one signed digit per cycle (zero-padded for the flush), and the
// N+1 result digits are captured and compared digit-exact with the ROM sum.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             one-cycle run request, ignored while busy
//   test_sel          ROM vector index
//   x_vec, y_vec      ROM operands, MSD in the top digit
//   z_vec             ROM expected sum (N+1 digits), MSD in the top digit
//   adder_clr         clears the adder state before each vector
//   dig_vld           x_dig/y_dig valid; the adder advances one digit
//   x_dig, y_dig      operand digits, C-bit two's complement
//   z_dig             adder result digit
//   busy, done        run in progress / one-cycle end-of-run pulse
//   pass              every vector of the last run matched
//   fail_cnt          failing vectors in the last run (saturates at 1023)
//   fail_idx          first failing vector index
//   fail_pos          first mismatching digit of that vector, 0 = MSD
//
// Build option: define ONLINE_SEQ_ERR_LOG_EN to build the first-failure log
// (fail_idx/fail_pos); otherwise both ports are tied to 0.
module online_adder_seq_r4 #(
  parameter int N       = 6,
  parameter int C       = 3,
  parameter int LAT     = 2,
  parameter int NUM_TST = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [9:0]           test_sel,
  input  logic [N*C-1:0]       x_vec,
  input  logic [N*C-1:0]       y_vec,
  input  logic [(N+1)*C-1:0]   z_vec,
  output logic                 adder_clr,
  output logic                 dig_vld,
  output logic [C-1:0]         x_dig,
  output logic [C-1:0]         y_dig,
  input  logic [C-1:0]         z_dig,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [9:0]           fail_cnt,
  output logic [9:0]           fail_idx,
  output logic [3:0]           fail_pos
);

  localparam int KW = $clog2(LAT + N + 1);
  localparam int XW = N * C;
  localparam int ZW = (N + 1) * C;

  typedef enum logic [2:0] {IDLE, SEL, LOAD, FEED, CHECK, FIN} state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k;
  logic [XW-1:0]   x_sh, y_sh;
  logic [ZW-1:0]   z_sh, res_sh;
  logic            mismatch;
  logic            last_vec;
  logic            feed_end;
  logic [9:0]      fail_cnt_nxt;

  assign last_vec     = (test_sel == 10'(NUM_TST - 1));
  assign feed_end     = (k == KW'(LAT + N));
  assign mismatch     = (res_sh != z_sh);
  // Saturate so a long run can never wrap back to an apparent pass.
  assign fail_cnt_nxt = (mismatch && (fail_cnt != 10'h3FF)) ? fail_cnt + 10'd1 : fail_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEL;
      SEL:     state_nxt = LOAD;
      LOAD:    state_nxt = FEED;
      FEED:    if (feed_end) state_nxt = CHECK;
      CHECK:   state_nxt = last_vec ? FIN : SEL;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state. The operand shift registers drain to
  // zero after N digits, which supplies the flush padding for free.
  always_comb begin
    adder_clr = 1'b0;
    dig_vld   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    x_dig     = '0;
    y_dig     = '0;
    case (state)
      SEL: begin
        busy      = 1'b1;
        adder_clr = 1'b1;
      end
      LOAD:  busy = 1'b1;
      FEED: begin
        busy    = 1'b1;
        dig_vld = 1'b1;
        x_dig   = x_sh[XW-1 -: C];
        y_dig   = y_sh[XW-1 -: C];
      end
      CHECK: busy = 1'b1;
      FIN:   done = 1'b1;
      default: ;
    endcase
  end

  // Vector sequencing, operand shadows, result capture and the tally.
  // pass is settled on the way into FIN so it is valid alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      test_sel <= '0;
      fail_cnt <= '0;
      pass     <= 1'b0;
      k        <= '0;
      x_sh     <= '0;
      y_sh     <= '0;
      z_sh     <= '0;
      res_sh   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          test_sel <= '0;
          fail_cnt <= '0;
          pass     <= 1'b0;
        end
        LOAD: begin
          x_sh <= x_vec;
          y_sh <= y_vec;
          z_sh <= z_vec;
          k    <= '0;
        end
        FEED: begin
          x_sh <= {x_sh[XW-C-1:0], {C{1'b0}}};
          y_sh <= {y_sh[XW-C-1:0], {C{1'b0}}};
          k    <= k + KW'(1);
          if (k >= KW'(LAT)) res_sh <= {res_sh[ZW-C-1:0], z_dig};
        end
        CHECK: begin
          fail_cnt <= fail_cnt_nxt;
          if (last_vec) pass <= (fail_cnt_nxt == 10'd0);
          else          test_sel <= test_sel + 10'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef ONLINE_SEQ_ERR_LOG_EN
  logic       logged;
  logic [3:0] first_pos;

  // Scan from LSD to MSD so the last hit is the most significant mismatch.
  always_comb begin
    first_pos = '0;
    for (int i = N; i >= 0; i--) begin
      if (res_sh[ZW-1-i*C -: C] != z_sh[ZW-1-i*C -: C]) first_pos = 4'(i);
    end
  end

  // First failure of a run is kept; later failures leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      logged   <= 1'b0;
      fail_idx <= '0;
      fail_pos <= '0;
    end else if (state == IDLE && start) begin
      logged   <= 1'b0;
      fail_idx <= '0;
      fail_pos <= '0;
    end else if (state == CHECK && mismatch && !logged) begin
      logged   <= 1'b1;
      fail_idx <= test_sel;
      fail_pos <= first_pos;
    end
  end
`else
  assign fail_idx = '0;
  assign fail_pos = '0;
`endif

endmodule

// File: tb/tb_online_adder_seq_r4.sv
// Testbench for online_adder_seq_r4: a three-entry vector ROM plus an ideal
// LAT=2 online adder model that replays hand-computed sum digits and records
// the operand digits it receives.
module tb_online_adder_seq_r4;

  localparam logic [2:0] D0 = 3'd0, P1 = 3'd1, P2 = 3'd2, P3 = 3'd3;
  localparam logic [2:0] M1 = 3'b111, M2 = 3'b110, M3 = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  test_sel;
  logic [17:0] x_vec, y_vec;
  logic [20:0] z_vec;
  logic        adder_clr, dig_vld;
  logic [2:0]  x_dig, y_dig, z_dig;
  logic        busy, done, pass;
  logic [9:0]  fail_cnt, fail_idx;
  logic [3:0]  fail_pos;

  int n_cmp = 0;
  int n_fail = 0;
  int mode = 0;          // 0 ideal, 1 LSD of vector 2 forced to 0, 2 digit 1 of every vector bumped
  int m_cnt = 0;
  int m_vec = 0;
  logic [2:0] xrec [0:2][0:8];
  logic [2:0] yrec [0:2][0:8];

  online_adder_seq_r4 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .test_sel(test_sel),
    .x_vec(x_vec), .y_vec(y_vec), .z_vec(z_vec),
    .adder_clr(adder_clr), .dig_vld(dig_vld), .x_dig(x_dig), .y_dig(y_dig),
    .z_dig(z_dig), .busy(busy), .done(done), .pass(pass),
    .fail_cnt(fail_cnt), .fail_idx(fail_idx), .fail_pos(fail_pos)
  );

  always #5 clk = ~clk;

  // Vector ROM, sums worked by hand (digit weights 4^6..4^0 for z).
  // v0: 1 + 2 = 3;  v1: 1391 + 1658 = 3049;  v2: 35 + 2 = 37.
  always_comb begin
    x_vec = '0;
    y_vec = '0;
    z_vec = '0;
    case (test_sel)
      10'd0: begin
        x_vec = {D0, D0, D0, D0, D0, P1};
        y_vec = {D0, D0, D0, D0, D0, P2};
        z_vec = {D0, D0, D0, D0, D0, D0, P3};
      end
      10'd1: begin
        x_vec = {P1, P2, M3, P3, D0, M1};
        y_vec = {P2, M1, M3, P3, P2, P2};
        z_vec = {P1, M1, D0, M1, P2, P2, P1};
      end
      10'd2: begin
        x_vec = {D0, D0, D0, P2, D0, P3};
        y_vec = {D0, D0, D0, D0, D0, P2};
        z_vec = {D0, D0, D0, D0, P2, P1, P1};
      end
      default: ;
    endcase
  end

  function automatic logic [20:0] model_sum(input int v);
    case (v)
      0:       return {D0, D0, D0, D0, D0, D0, P3};
      1:       return {P1, M1, D0, M1, P2, P2, P1};
      2:       return {D0, D0, D0, D0, P2, P1, P1};
      default: return '0;
    endcase
  endfunction

  // Adder model state: counts accepted digits since the last clear.
  always @(posedge clk) begin
    if (adder_clr) begin
      m_vec <= int'(test_sel);
      m_cnt <= 0;
    end else if (dig_vld) begin
      if (m_cnt < 9 && m_vec < 3) begin
        xrec[m_vec][m_cnt] <= x_dig;
        yrec[m_vec][m_cnt] <= y_dig;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  // Result digit m_cnt-2 appears while the m_cnt-th operand digit is fed.
  always_comb begin
    logic [20:0] s;
    s = model_sum(m_vec);
    z_dig = '0;
    if (dig_vld && m_cnt >= 2 && m_cnt <= 8) begin
      z_dig = s[20-(m_cnt-2)*3 -: 3];
      if (mode == 1 && m_vec == 2 && m_cnt == 8) z_dig = '0;
      if (mode == 2 && m_cnt == 3) z_dig = z_dig + 3'd1;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Waits for done; cycle 1 is the SEL cycle after the start edge.
  task automatic wait_done(output int cycles, output bit timed_out);
    cycles = 1;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0 || pass !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done_pass: got %0b/%0b want 0/0", done, pass); end
    n_cmp++; if (dig_vld !== 1'b0 || adder_clr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_vld_clr: got %0b/%0b want 0/0", dig_vld, adder_clr); end
    n_cmp++; if (x_dig !== 3'd0 || y_dig !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_digits: got %0d/%0d want 0/0", x_dig, y_dig); end
    n_cmp++; if (test_sel !== 10'd0 || fail_cnt !== 10'd0) begin n_fail++; $display("[TB] FAIL reset_sel_cnt: got %0d/%0d want 0/0", test_sel, fail_cnt); end
    n_cmp++; if (fail_idx !== 10'd0 || fail_pos !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_log: got %0d/%0d want 0/0", fail_idx, fail_pos); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ideal_run();
    int cyc;
    bit to;
    logic [2:0] xe [9];
    logic [2:0] ye [9];
    xe = '{P1, P2, M3, P3, D0, M1, D0, D0, D0};
    ye = '{P2, M1, M3, P3, P2, P2, D0, D0, D0};
    mode = 0;
    pulse_start();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL run_busy: got %0b want 1", busy); end
    wait_done(cyc, to);
    n_cmp++; if (to) begin n_fail++; $display("[TB] FAIL run_timeout: got no done want done"); end
    n_cmp++; if (cyc != 37) begin n_fail++; $display("[TB] FAIL run_latency: got %0d want 37", cyc); end
    n_cmp++; if (pass !== 1'b1 || fail_cnt !== 10'd0) begin n_fail++; $display("[TB] FAIL run_pass: got pass=%0b cnt=%0d want 1/0", pass, fail_cnt); end
    n_cmp++; if (busy !== 1'b0 || test_sel !== 10'd2) begin n_fail++; $display("[TB] FAIL run_fin: got busy=%0b sel=%0d want 0/2", busy, test_sel); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (xrec[1][i] !== xe[i]) begin n_fail++; $display("[TB] FAIL v1_x_dig%0d: got %0d want %0d", i, $signed(xrec[1][i]), $signed(xe[i])); end
      n_cmp++; if (yrec[1][i] !== ye[i]) begin n_fail++; $display("[TB] FAIL v1_y_dig%0d: got %0d want %0d", i, $signed(yrec[1][i]), $signed(ye[i])); end
    end
    n_cmp++; if (xrec[0][5] !== P1 || yrec[0][5] !== P2) begin n_fail++; $display("[TB] FAIL v0_lsd: got %0d/%0d want 1/2", xrec[0][5], yrec[0][5]); end
    n_cmp++; if (xrec[2][3] !== P2 || xrec[2][5] !== P3) begin n_fail++; $display("[TB] FAIL v2_x: got %0d/%0d want 2/3", xrec[2][3], xrec[2][5]); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || pass !== 1'b1 || test_sel !== 10'd2) begin n_fail++; $display("[TB] FAIL after_fin: got done=%0b pass=%0b sel=%0d want 0/1/2", done, pass, test_sel); end
  endtask

  task automatic test_lsd_fault();
    int cyc;
    bit to;
    mode = 1;
    pulse_start();
    n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("[TB] FAIL lsd_pass_cleared: got %0b want 0", pass); end
    wait_done(cyc, to);
    n_cmp++; if (to) begin n_fail++; $display("[TB] FAIL lsd_timeout: got no done want done"); end
    n_cmp++; if (pass !== 1'b0 || fail_cnt !== 10'd1) begin n_fail++; $display("[TB] FAIL lsd_result: got pass=%0b cnt=%0d want 0/1", pass, fail_cnt); end
`ifdef ONLINE_SEQ_ERR_LOG_EN
    n_cmp++; if (fail_idx !== 10'd2 || fail_pos !== 4'd6) begin n_fail++; $display("[TB] FAIL lsd_log: got idx=%0d pos=%0d want 2/6", fail_idx, fail_pos); end
`else
    n_cmp++; if (fail_idx !== 10'd0 || fail_pos !== 4'd0) begin n_fail++; $display("[TB] FAIL lsd_log_tied: got idx=%0d pos=%0d want 0/0", fail_idx, fail_pos); end
`endif
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int cyc = 0;
    int ndone = 0;
    int done_at = 0;
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) cyc = 1;
    if (done) begin ndone++; done_at = cyc; end
    @(negedge clk) start = 1'b0;
    cyc = 2;
    if (done) begin ndone++; done_at = cyc; end
    while (cyc < 90) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 15 || cyc == 30);
      if (done) begin ndone++; done_at = cyc; end
    end
    start = 1'b0;
    n_cmp++; if (ndone != 1) begin n_fail++; $display("[TB] FAIL start_ignored_done_count: got %0d want 1", ndone); end
    n_cmp++; if (done_at != 37) begin n_fail++; $display("[TB] FAIL start_ignored_done_cycle: got %0d want 37", done_at); end
    n_cmp++; if (busy !== 1'b0 || pass !== 1'b1 || fail_cnt !== 10'd0) begin n_fail++; $display("[TB] FAIL start_ignored_state: got busy=%0b pass=%0b cnt=%0d want 0/1/0", busy, pass, fail_cnt); end
  endtask

  task automatic test_all_fail();
    int cyc;
    bit to;
    mode = 2;
    pulse_start();
    wait_done(cyc, to);
    n_cmp++; if (to) begin n_fail++; $display("[TB] FAIL allfail_timeout: got no done want done"); end
    n_cmp++; if (pass !== 1'b0 || fail_cnt !== 10'd3) begin n_fail++; $display("[TB] FAIL allfail_result: got pass=%0b cnt=%0d want 0/3", pass, fail_cnt); end
`ifdef ONLINE_SEQ_ERR_LOG_EN
    n_cmp++; if (fail_idx !== 10'd0 || fail_pos !== 4'd1) begin n_fail++; $display("[TB] FAIL allfail_log: got idx=%0d pos=%0d want 0/1", fail_idx, fail_pos); end
`else
    n_cmp++; if (fail_idx !== 10'd0 || fail_pos !== 4'd0) begin n_fail++; $display("[TB] FAIL allfail_log_tied: got idx=%0d pos=%0d want 0/0", fail_idx, fail_pos); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid_feed();
    int guard = 0;
    int cyc;
    bit to;
    mode = 2;
    pulse_start();
    while (!(dig_vld && test_sel == 10'd1 && m_cnt == 3) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++; if (guard >= 100) begin n_fail++; $display("[TB] FAIL midfeed_reach: got timeout want vector 1 feed"); end
    n_cmp++; if (fail_cnt !== 10'd1) begin n_fail++; $display("[TB] FAIL midfeed_precount: got %0d want 1", fail_cnt); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || dig_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL midfeed_reset_ctrl: got busy=%0b vld=%0b want 0/0", busy, dig_vld); end
    n_cmp++; if (test_sel !== 10'd0 || fail_cnt !== 10'd0) begin n_fail++; $display("[TB] FAIL midfeed_reset_regs: got sel=%0d cnt=%0d want 0/0", test_sel, fail_cnt); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || adder_clr !== 1'b0) begin n_fail++; $display("[TB] FAIL midfeed_hold: got busy=%0b clr=%0b want 0/0", busy, adder_clr); end
    rst_n = 1'b1;
    @(negedge clk);
    mode = 0;
    pulse_start();
    wait_done(cyc, to);
    n_cmp++; if (to || cyc != 37 || pass !== 1'b1) begin n_fail++; $display("[TB] FAIL recover_run: got to=%0b cyc=%0d pass=%0b want 0/37/1", to, cyc, pass); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ideal_run();
    test_lsd_fault();
    test_start_ignored();
    test_all_fail();
    test_reset_mid_feed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
